// File: rtl/avmm_rd_arbiter_pkg.sv
// Shared types and helpers for the Avalon-MM read arbiter.
// Optional error checking in the top is enabled by defining AVMM_ARB_ERR_CHK_EN.
package avmm_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // Largest requester count the round-robin helper supports.
  localparam int MAX_REQ = 8;

  // Widths for the default configuration (4 requesters, 4 outstanding).
  localparam int TAG_W = $clog2(4);
  localparam int CNT_W = $clog2(4 + 1);

  // Round-robin pick: first asserted request scanning ptr, ptr+1, ... mod n.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && (k < n) && req[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/avmm_rd_arbiter_if.sv
// Requester-side and memory-side Avalon-MM read signals of the arbiter.
interface avmm_rd_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  // Handshake: a requester raises req_read with a stable address and keeps
  // both held while its req_waitrequest is 1; the command is taken in the
  // single cycle its req_waitrequest is 0. The memory side uses the same rule
  // with m_read/m_waitrequest. Returns carry no backpressure: a one-cycle
  // readdatavalid strobe delivers readdata, in command issue order.
  logic [N_REQ-1:0]        req_read;
  logic [N_REQ*ADDR_W-1:0] req_address;
  logic [N_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]       req_readdata;
  logic [N_REQ-1:0]        req_readdatavalid;
  logic [ADDR_W-1:0]       m_address;
  logic                    m_read;
  logic [DATA_W-1:0]       m_readdata;
  logic                    m_readdatavalid;
  logic                    m_waitrequest;

  // Arbiter view.
  modport slave (
    input  req_read, req_address, m_readdata, m_readdatavalid, m_waitrequest,
    output req_waitrequest, req_readdata, req_readdatavalid, m_address, m_read
  );

  // Environment view (requesters plus memory).
  modport master (
    output req_read, req_address, m_readdata, m_readdatavalid, m_waitrequest,
    input  req_waitrequest, req_readdata, req_readdatavalid, m_address, m_read
  );
endinterface

// File: rtl/avmm_rd_arbiter_tag_fifo.sv
// Tag FIFO holding the requester index of each outstanding read, first-word
// fall-through. Push and pop in the same cycle are allowed even when full.
module avmm_arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/avmm_rd_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read port between N_REQ masters.
// Returns are routed back by a tag FIFO recording the issuing requester.
// Define AVMM_ARB_ERR_CHK_EN to build the sticky protocol-error flag.
module avmm_rd_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  avmm_rd_arbiter_if.slave                 bus,
  output logic                             busy,
  output logic                             err,
  output arb_state_t                       state_dbg,
  output logic [$clog2(MAX_OUT+1)-1:0]     out_cnt_dbg
);
  localparam int TAG_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_BITS = $clog2(MAX_OUT + 1);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [TAG_BITS-1:0] grant_idx;
  logic [TAG_BITS-1:0] rr_ptr;
  logic [TAG_BITS-1:0] winner;
  logic [TAG_BITS-1:0] ret_tag;
  logic [CNT_BITS-1:0] out_cnt;
  logic [ADDR_W-1:0]   m_address_q;
  logic                m_read_q;
  logic                any_req;
  logic                can_issue;
  logic                grant;
  logic                accept;
  logic                ret;
  logic                fifo_full;
  logic                fifo_empty;

  // Round-robin winner among current requests, starting at rr_ptr.
  always_comb begin
    any_req   = |bus.req_read;
    winner    = TAG_BITS'(rr_pick(8'(bus.req_read), 3'(rr_ptr), N_REQ));
    can_issue = (out_cnt < CNT_BITS'(MAX_OUT)) && !fifo_full;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus grant/accept strobes.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && can_issue) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.m_waitrequest) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command register: latched on grant, held through memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx   <= '0;
      rr_ptr      <= '0;
      m_address_q <= '0;
      m_read_q    <= 1'b0;
    end else if (grant) begin
      grant_idx   <= winner;
      m_address_q <= bus.req_address[winner*ADDR_W +: ADDR_W];
      m_read_q    <= 1'b1;
    end else if (accept) begin
      m_read_q <= 1'b0;
      rr_ptr   <= (grant_idx == TAG_BITS'(N_REQ - 1)) ? '0 : grant_idx + TAG_BITS'(1);
    end
  end

  // Outstanding-read counter; accept and return in one cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      case ({accept, ret})
        2'b10:   out_cnt <= out_cnt + CNT_BITS'(1);
        2'b01:   out_cnt <= out_cnt - CNT_BITS'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  avmm_arb_tag_fifo #(
    .W     (TAG_BITS),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (grant_idx),
    .pop   (ret),
    .dout  (ret_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Return routing and per-requester stall, all combinational.
  always_comb begin
    ret                   = bus.m_readdatavalid && !fifo_empty;
    bus.req_readdatavalid = '0;
    if (ret) bus.req_readdatavalid[ret_tag] = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_waitrequest[i] = !(accept && (grant_idx == TAG_BITS'(i)));
    end
  end

  assign bus.req_readdata = bus.m_readdata;
  assign bus.m_address    = m_address_q;
  assign bus.m_read       = m_read_q;
  assign busy             = (state == ISSUE) || (out_cnt != '0);
  assign state_dbg        = state;
  assign out_cnt_dbg      = out_cnt;

`ifdef AVMM_ARB_ERR_CHK_EN
  logic err_q;

  // Sticky flag: return with nothing outstanding, or granted requester
  // withdrawing its read before acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((bus.m_readdatavalid && fifo_empty) ||
                 ((state == ISSUE) && !bus.req_read[grant_idx])) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_rd_arbiter.sv
// Directed bench for avmm_rd_arbiter: requester and memory models, a grant
// and a return scoreboard checked by a negedge monitor, and a final report.
module tb_avmm_rd_arbiter;
  import avmm_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 4;
`ifdef AVMM_ARB_ERR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avmm_rd_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic       busy;
  logic       err;
  arb_state_t state_dbg;
  logic [2:0] out_cnt_dbg;

  avmm_rd_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .err         (err),
    .state_dbg   (state_dbg),
    .out_cnt_dbg (out_cnt_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [35:0] gnt_q[$];   // {requester index, address} in expected grant order
  logic [67:0] exp_q[$];   // {strobe, data} in expected return order
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return (a == 32'h8) ? 64'h0807060504030201 : {a ^ 32'hA5A5_A5A5, a};
  endfunction

  // ---------------- requester model ----------------
  logic [4:0]       loaded [N_REQ];
  logic [4:0]       taken  [N_REQ] = '{default: 5'd0};
  logic [31:0]      addr_tab [N_REQ][32];
  logic [N_REQ-1:0] drop_mask;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_read[i] = (loaded[i] != taken[i]) && !drop_mask[i];
      bus.req_address[i*ADDR_W +: ADDR_W] = addr_tab[i][taken[i]];
    end
  end

  // Queue one command for requester i; calls are made in expected grant order.
  task automatic load(input int i, input logic [31:0] a, input logic [63:0] d);
    addr_tab[i][loaded[i]] = a;
    loaded[i] = loaded[i] + 5'd1;
    gnt_q.push_back({4'(i), a});
    exp_q.push_back({4'(1 << i), d});
  endtask

  // ---------------- memory model ----------------
  logic [31:0] acc_log [64];
  int   acc_n    = 0;
  int   ret_n    = 0;
  int   bad_req  = 0;
  int   bad_done = 0;
  logic ret_en   = 1'b1;

  initial begin
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_readdatavalid = 1'b0;
      if (bad_done != bad_req) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 64'hDEAD_BEEF_0000_0000;
        bad_done++;
      end else if (ret_en && (ret_n != acc_n)) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = mem_data(acc_log[ret_n % 64]);
        ret_n++;
      end
    end
  end

  // ---------------- monitor ----------------
  int model_cnt = 0;

  always @(negedge clk) begin
    logic [35:0] g;
    logic [67:0] e;
    int idx;
    if (!rst_n) begin
      model_cnt = 0;
    end else begin
      check("out_cnt", 64'(out_cnt_dbg), 64'(model_cnt));
      if (bus.req_waitrequest != '1) begin
        idx = 0;
        for (int i = 0; i < N_REQ; i++) if (!bus.req_waitrequest[i]) idx = i;
        check("accept_onehot", 64'($countones(~bus.req_waitrequest)), 64'd1);
        check("m_read_at_accept", 64'(bus.m_read), 64'd1);
        check("grant_expected", 64'(gnt_q.size() != 0), 64'd1);
        if (gnt_q.size() != 0) begin
          g = gnt_q.pop_front();
          check("grant_idx", 64'(idx), 64'(g[35:32]));
          check("grant_addr", 64'(bus.m_address), 64'(g[31:0]));
        end
        acc_log[acc_n % 64] = bus.m_address;
        acc_n++;
        taken[idx] = taken[idx] + 5'd1;
        model_cnt++;
      end
      if (bus.req_readdatavalid != '0) begin
        check("return_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ret_strobe", 64'(bus.req_readdatavalid), 64'(e[67:64]));
          check("ret_data", bus.req_readdata, e[63:0]);
        end
        model_cnt--;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_issue();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state_dbg == ISSUE) break;
    end
    check("wait_issue", 64'(state_dbg), 64'(ISSUE));
  endtask

  task automatic wait_gnt();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt_q.size() == 0) break;
    end
    check("wait_grant", 64'(gnt_q.size()), 64'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (gnt_q.size() == 0 && exp_q.size() == 0) break;
    end
    check("drain_grants", 64'(gnt_q.size()), 64'd0);
    check("drain_returns", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.m_waitrequest = 1'b0;
    drop_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      loaded[i] = 5'd0;
      for (int j = 0; j < 32; j++) addr_tab[i][j] = '0;
    end
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_m_read", 64'(bus.m_read), 64'd0);
    check("rst_m_address", 64'(bus.m_address), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_waitrequest", 64'(bus.req_waitrequest), 64'hF);
    check("rst_rdv", 64'(bus.req_readdatavalid), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_out_cnt", 64'(out_cnt_dbg), 64'd0);
    rst_n = 1'b1;

    // Single request from requester 0.
    @(negedge clk);
    load(0, 32'h8, 64'h0807060504030201);
    drain();
    check("single_out_cnt", 64'(out_cnt_dbg), 64'd0);

    // Contention from reset: 0,1,2,3,0,1,2,3; then only 1 and 3: 1,3,1,3.
    @(negedge clk);
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_REQ; i++)
        load(i, 32'h1000 + 32'(i * 256 + r * 16), mem_data(32'h1000 + 32'(i * 256 + r * 16)));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain();
    load(1, 32'h2100, mem_data(32'h2100));
    load(3, 32'h2300, mem_data(32'h2300));
    load(1, 32'h2110, mem_data(32'h2110));
    load(3, 32'h2310, mem_data(32'h2310));
    drain();

    // Stall: 5 cycles of waitrequest, requester 0 waiting behind grant 2.
    @(negedge clk);
    bus.m_waitrequest = 1'b1;
    load(2, 32'h200, mem_data(32'h200));
    wait_issue();
    load(0, 32'h300, mem_data(32'h300));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_m_read", 64'(bus.m_read), 64'd1);
      check("stall_m_address", 64'(bus.m_address), 64'h200);
      check("stall_waitrequest", 64'(bus.req_waitrequest), 64'hF);
    end
    @(posedge clk);
    #1 bus.m_waitrequest = 1'b0;
    drain();

    // Outstanding limit: six pending, returns withheld, exactly four issued.
    do_reset();
    ret_en = 1'b0;
    load(0, 32'h4000, mem_data(32'h4000));
    load(1, 32'h4100, mem_data(32'h4100));
    load(2, 32'h4200, mem_data(32'h4200));
    load(3, 32'h4300, mem_data(32'h4300));
    load(0, 32'h4010, mem_data(32'h4010));
    load(1, 32'h4110, mem_data(32'h4110));
    repeat (20) @(negedge clk);
    check("limit_out_cnt", 64'(out_cnt_dbg), 64'd4);
    check("limit_m_read", 64'(bus.m_read), 64'd0);
    check("limit_busy", 64'(busy), 64'd1);
    check("limit_state", 64'(state_dbg), 64'(IDLE));
    check("limit_pending", 64'(gnt_q.size()), 64'd2);
    ret_en = 1'b1;
    drain();

    // Interleaved: 2 and 0 outstanding, returns start as 3 is accepted.
    ret_en = 1'b0;
    load(2, 32'h5200, mem_data(32'h5200));
    wait_gnt();
    load(0, 32'h5000, mem_data(32'h5000));
    wait_gnt();
    ret_en = 1'b1;
    load(3, 32'h5300, mem_data(32'h5300));
    drain();

    // Granted requester withdraws during a stall; command still completes.
    @(negedge clk);
    bus.m_waitrequest = 1'b1;
    load(1, 32'h6100, mem_data(32'h6100));
    wait_issue();
    drop_mask[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("drop_m_read", 64'(bus.m_read), 64'd1);
    check("drop_m_address", 64'(bus.m_address), 64'h6100);
    @(posedge clk);
    #1 bus.m_waitrequest = 1'b0;
    drain();
    drop_mask = '0;
    check("drop_err", 64'(err), 64'(ERR_EXP));
    do_reset();
    @(negedge clk);
    check("drop_err_cleared", 64'(err), 64'd0);

    // Unexpected return with nothing outstanding.
    bad_req = bad_req + 1;
    @(negedge clk);
    check("bad_rdv_seen", 64'(bus.m_readdatavalid), 64'd1);
    check("bad_no_strobe", 64'(bus.req_readdatavalid), 64'd0);
    @(negedge clk);
    check("bad_err", 64'(err), 64'(ERR_EXP));
    check("bad_out_cnt", 64'(out_cnt_dbg), 64'd0);
    check("bad_busy", 64'(busy), 64'd0);
    do_reset();
    @(negedge clk);
    check("bad_err_cleared", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
